// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SUBLEQ memory port arbiter.
// Holds the arbiter state encoding, default latency/lock limits and the ID width helper.
// No logic lives here; every consumer imports it.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int READ_LAT_DEF = 2;
    localparam int LOCK_MAX_DEF = 16;

    // Bits needed to index n items; never less than one bit.
    function automatic int calc_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/read_tag_pipe.sv
// Delay line carrying {valid, requester id} for each accepted read.
// Latency: exactly DEPTH cycles from in_valid to out_valid.
// No backpressure: a new entry may enter every cycle; reset drops all entries.
module read_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = READ_LAT_DEF,
    parameter int ID_W  = 1
) (
    input  logic            clock,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id
);

    logic [DEPTH-1:0] vld;
    logic [ID_W-1:0]  tag [DEPTH];

    // Shift the read tags one stage per cycle; reset discards in-flight reads.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            tag[0] <= in_id;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_id    = tag[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one SUBLEQ memory port, with per-requester lock and read return routing.
// Latency: grant and memory drive are same-cycle; read data returns READ_LAT cycles after acceptance.
// Backpressure: req_ready is a one-hot grant; requesters hold their request until accepted.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = READ_LAT_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      lock_timeout,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    input  logic [DATA_W-1:0]         mem_dout
);

    localparam int ID_W  = calc_id_w(NUM_REQ);
    localparam int CNT_W = calc_id_w(LOCK_MAX);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    // Successor in round-robin order, wrapping at NUM_REQ (which need not be a power of two).
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == LAST_ID) ? '0 : id + 1'b1;
    endfunction

    arb_state_t       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  owner;
    logic [CNT_W-1:0] lock_cnt;

    logic             gnt_any;
    logic [ID_W-1:0]  gnt_id;
    logic             owner_release;
    logic             pipe_vld;
    logic [ID_W-1:0]  pipe_id;

    // Pick the granted requester: only the owner while locked, else first valid at or after rr_ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        if (state == ARB_LOCKED) begin
            gnt_any = req_valid[owner];
            gnt_id  = owner;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gnt_any && req_valid[i] && (i >= int'(rr_ptr))) begin
                    gnt_any = 1'b1;
                    gnt_id  = ID_W'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gnt_any && req_valid[i] && (i < int'(rr_ptr))) begin
                    gnt_any = 1'b1;
                    gnt_id  = ID_W'(i);
                end
            end
        end
    end

    // One-hot ready for the granted requester.
    always_comb begin
        req_ready = '0;
        if (gnt_any) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign mem_en   = gnt_any;
    assign mem_we   = gnt_any & req_we[gnt_id];
    assign mem_addr = gnt_any ? req_addr[int'(gnt_id)*ADDR_W +: ADDR_W]  : '0;
    assign mem_din  = gnt_any ? req_wdata[int'(gnt_id)*DATA_W +: DATA_W] : '0;

    // A release landing on the last allowed cycle wins over the timeout, so no pulse then.
    assign owner_release = (state == ARB_LOCKED) && gnt_any && !req_lock[owner];
    assign lock_timeout  = (state == ARB_LOCKED) && (lock_cnt == CNT_LAST) && !owner_release;

    // Arbitration state: rotate the pointer on open grants, enter/leave the lock, age the lock.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state    <= ARB_OPEN;
            rr_ptr   <= '0;
            owner    <= '0;
            lock_cnt <= '0;
        end else begin
            case (state)
                ARB_OPEN: begin
                    if (gnt_any) begin
                        rr_ptr <= next_id(gnt_id);
                        if (req_lock[gnt_id]) begin
                            state    <= ARB_LOCKED;
                            owner    <= gnt_id;
                            lock_cnt <= '0;
                        end
                    end
                end
                ARB_LOCKED: begin
                    lock_cnt <= lock_cnt + 1'b1;
                    if (owner_release || lock_timeout) begin
                        state    <= ARB_OPEN;
                        rr_ptr   <= next_id(owner);
                        lock_cnt <= '0;
                    end
                end
                default: state <= ARB_OPEN;
            endcase
        end
    end

    read_tag_pipe #(
        .DEPTH (READ_LAT),
        .ID_W  (ID_W)
    ) u_tag_pipe (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (gnt_any & ~req_we[gnt_id]),
        .in_id     (gnt_id),
        .out_valid (pipe_vld),
        .out_id    (pipe_id)
    );

    // Route the returning read data to the requester that issued it.
    always_comb begin
        rsp_valid = '0;
        if (pipe_vld) begin
            rsp_valid[pipe_id] = 1'b1;
        end
    end

    assign rsp_rdata = pipe_vld ? mem_dout : '0;

endmodule
